// File: rtl/spi_master_pkg.sv
// Shared definitions for the mode-0 SPI master: state encoding, frame width
// and clock polarity/phase constants.
package spi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    localparam int FRAME_W  = 8;
    localparam int BITCNT_W = $clog2(FRAME_W + 1);

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    // Phase whose last cycle captures the incoming bit (leading-edge sampling for CPHA=0).
    localparam state_e SAMPLE_ST = (CPHA == 1'b0) ? ST_HIGH : ST_LOW;

    function automatic logic sclk_level(input state_e st);
        return (st == ST_HIGH) ? ~CPOL : CPOL;
    endfunction

endpackage

// File: rtl/spi_master_shiftreg8.sv
// Frame shift register: parallel load, shifts toward the MSB so the MSB is the
// outgoing bit and received bits enter at the LSB.
module spi_master_shiftreg8
    import spi_master_pkg::*;
(
    input  logic               clk_i,
    input  logic               load_i,
    input  logic [FRAME_W-1:0] data_i,
    input  logic               shift_i,
    input  logic               ser_i,
    output logic [FRAME_W-1:0] q_o
);

    logic [FRAME_W-1:0] sr_q;
    logic [FRAME_W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = {sr_q[FRAME_W-2:0], ser_i};
        end
    end

    always_ff @(posedge clk_i) begin
        sr_q <= sr_d;
    end

    assign q_o = sr_q;

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI mode-0 master. Every non-idle phase lasts HALFPERIOD clocks;
// all outputs come straight from flops.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int HALFPERIOD   = 4,
    parameter int COUNTERWIDTH = 3
) (
    input  logic               clk_i,
    input  logic               resetn_i,
    input  logic               start_i,
    input  logic [FRAME_W-1:0] txdata_i,
    output logic [FRAME_W-1:0] rxdata_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               cs_o,
    output logic               sclk_o,
    output logic               mosi_o,
    input  logic               miso_i
);

    localparam logic [COUNTERWIDTH-1:0] PHASE_LAST = COUNTERWIDTH'(HALFPERIOD - 1);
    localparam logic [BITCNT_W-1:0]     LAST_BIT   = BITCNT_W'(FRAME_W - 1);

    state_e                  state_q, state_d;
    logic [COUNTERWIDTH-1:0] cnt_q, cnt_d;
    logic [BITCNT_W-1:0]     bit_q, bit_d;
    logic [1:0]              sync_q;

    logic                    cs_q, cs_d;
    logic                    sclk_q, sclk_d;
    logic                    mosi_q, mosi_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [FRAME_W-1:0]      rx_q, rx_d;

    logic                    phase_last;
    logic                    accept;
    logic                    sample;
    logic [FRAME_W-1:0]      sr;

    assign phase_last = (cnt_q == PHASE_LAST);
    assign accept     = (state_q == ST_IDLE) && start_i;
    assign sample     = (state_q == SAMPLE_ST) && phase_last;

    spi_master_shiftreg8 u_shiftreg (
        .clk_i  (clk_i),
        .load_i (accept),
        .data_i (txdata_i),
        .shift_i(sample),
        .ser_i  (sync_q[1]),
        .q_o    (sr)
    );

    // miso is asynchronous to clk_i; only sync_q[1] is ever consumed.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], miso_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_i)    state_d = ST_SETUP;
            ST_SETUP: if (phase_last) state_d = ST_HIGH;
            ST_HIGH:  if (phase_last) state_d = (bit_q == LAST_BIT) ? ST_HOLD : ST_LOW;
            ST_LOW:   if (phase_last) state_d = ST_HIGH;
            ST_HOLD:  if (phase_last) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + COUNTERWIDTH'(1);
        if ((state_q == ST_IDLE) || phase_last) begin
            cnt_d = '0;
        end

        bit_d = bit_q;
        if (accept) begin
            bit_d = '0;
        end else if (sample) begin
            bit_d = bit_q + BITCNT_W'(1);
        end
    end

    // Outputs are derived from the next state so the flops line up with state_q.
    always_comb begin
        cs_d   = (state_d == ST_IDLE);
        sclk_d = sclk_level(state_d);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_HOLD) && phase_last;
        rx_d   = done_d ? sr : rx_q;

        mosi_d = mosi_q;
        if (state_d == ST_IDLE) begin
            mosi_d = 1'b0;
        end else if (accept) begin
            mosi_d = txdata_i[FRAME_W-1];
        end else if (sample && (state_d == ST_LOW)) begin
            mosi_d = sr[FRAME_W-2];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            cs_q   <= 1'b1;
            sclk_q <= CPOL;
            mosi_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rx_q   <= '0;
        end else begin
            cs_q   <= cs_d;
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
            busy_q <= busy_d;
            done_q <= done_d;
            rx_q   <= rx_d;
        end
    end

    assign cs_o     = cs_q;
    assign sclk_o   = sclk_q;
    assign mosi_o   = mosi_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign rxdata_o = rx_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: table of transfers (fixed and random)
// against a frame-level model, plus reset-abort and back-to-back sequences.
module tb_spi_master;

    localparam int H   = 4;
    localparam int CW  = 3;
    localparam int LAT = 17 * H + 1;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] txdata = 8'h00;
    logic [7:0] rxdata;
    logic       busy, done, cs, sclk, mosi;
    logic       miso;

    logic       loop = 1'b1;
    logic [7:0] slave_byte = 8'h00;
    logic [7:0] sl_sh = 8'h00;

    assign miso = loop ? mosi : sl_sh[7];

    always #5 clk = ~clk;

    spi_master #(.HALFPERIOD(H), .COUNTERWIDTH(CW)) dut (
        .clk_i   (clk),
        .resetn_i(resetn),
        .start_i (start),
        .txdata_i(txdata),
        .rxdata_o(rxdata),
        .busy_o  (busy),
        .done_o  (done),
        .cs_o    (cs),
        .sclk_o  (sclk),
        .mosi_o  (mosi),
        .miso_i  (miso)
    );

    int checks = 0;
    int errors = 0;

    int         edge_n, done_cnt, first_done, cs_gap, phase_bad, iface_bad, hi_len, lo_len;
    bit         bits[$];
    logic [7:0] rx_hist[$];
    logic       prev_cs, prev_sclk;
    logic [7:0] prev_rx;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] sl;
        bit         lp;
        int         poke;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vt[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_rx(input logic [7:0] tx, input logic [7:0] sl, input bit lp);
        return lp ? tx : sl;
    endfunction

    task automatic clear_stats();
        edge_n = 0; done_cnt = 0; first_done = 0; cs_gap = 0;
        phase_bad = 0; iface_bad = 0; hi_len = 0; lo_len = 0;
        bits.delete();
        rx_hist.delete();
        prev_cs = cs; prev_sclk = sclk; prev_rx = rxdata;
    endtask

    // One clock: advance an edge, then sample everything on the falling edge.
    task automatic tick();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        if (done === 1'b1) begin
            done_cnt++;
            rx_hist.push_back(rxdata);
            if (first_done == 0) first_done = edge_n;
        end
        if (cs === 1'b1 && done_cnt == 1) cs_gap++;
        if (busy !== ~cs) iface_bad++;
        if (cs === 1'b1 && (sclk !== 1'b0 || mosi !== 1'b0)) iface_bad++;
        if (resetn && rxdata !== prev_rx && done !== 1'b1) iface_bad++;
        if (sclk && !prev_sclk) begin
            bits.push_back(mosi);
            if (lo_len != H) phase_bad++;
            lo_len = 0;
        end
        if (!sclk && prev_sclk) begin
            if (hi_len != H) phase_bad++;
            hi_len = 0;
        end
        if (cs && !prev_cs && lo_len != H) phase_bad++;
        if (sclk) hi_len++;
        else if (!cs) lo_len++;
        else lo_len = 0;
        if (!cs && prev_cs) sl_sh = slave_byte;
        else if (!sclk && prev_sclk) sl_sh = sl_sh << 1;
        prev_cs = cs; prev_sclk = sclk; prev_rx = rxdata;
    endtask

    function automatic logic [15:0] pack_bits();
        logic [15:0] v = '0;
        foreach (bits[i]) v = {v[14:0], bits[i]};
        return v;
    endfunction

    task automatic xfer(input string tag, input logic [7:0] tx, input logic [7:0] sl,
                        input bit lp, input int poke, input logic [7:0] exp_rx);
        clear_stats();
        loop = lp; slave_byte = sl;
        start = 1'b1; txdata = tx;
        tick();
        check({tag, " busy@accept"}, busy, 1'b1);
        while (done_cnt == 0 && edge_n < 300) begin
            if (edge_n == poke) begin
                start = 1'b1; txdata = 8'h00;
            end else begin
                start = 1'b0; txdata = 8'($urandom);
            end
            tick();
        end
        start = 1'b0;
        check({tag, " done seen"}, done_cnt, 1);
        check({tag, " latency"}, first_done, LAT);
        for (int i = 0; i < 3; i++) tick();
        check({tag, " single done"}, done_cnt, 1);
        check({tag, " idle after"}, busy, 1'b0);
        check({tag, " sclk rises"}, bits.size(), 8);
        check({tag, " mosi bits"}, pack_bits(), {8'h00, tx});
        check({tag, " rxdata"}, rxdata, exp_rx);
        check({tag, " phase lengths"}, phase_bad, 0);
        check({tag, " iface"}, iface_bad, 0);
    endtask

    initial begin
        // Reset then idle.
        resetn = 1'b0;
        clear_stats();
        tick();
        tick();
        check("rst cs", cs, 1'b1);
        check("rst sclk", sclk, 1'b0);
        check("rst mosi", mosi, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst rxdata", rxdata, 8'h00);
        resetn = 1'b1;

        vt[0] = '{tx: 8'hA5, sl: 8'h00, lp: 1'b1, poke: 0,  exp_rx: 8'hA5};
        vt[1] = '{tx: 8'hFF, sl: 8'h3C, lp: 1'b0, poke: 0,  exp_rx: 8'h3C};
        vt[2] = '{tx: 8'h5A, sl: 8'hC3, lp: 1'b0, poke: 10, exp_rx: 8'hC3};
        vt[3] = '{tx: 8'h00, sl: 8'hFF, lp: 1'b0, poke: 0,  exp_rx: 8'hFF};
        vt[4] = '{tx: 8'h81, sl: 8'h7E, lp: 1'b0, poke: 0,  exp_rx: 8'h7E};
        for (int i = 5; i < 12; i++) begin
            vt[i].tx   = 8'($urandom);
            vt[i].sl   = 8'($urandom);
            vt[i].lp   = 1'($urandom_range(0, 1));
            vt[i].poke = ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 60)) : 0;
            vt[i].exp_rx = model_rx(vt[i].tx, vt[i].sl, vt[i].lp);
        end
        for (int i = 0; i < 12; i++) begin
            xfer($sformatf("vec%0d", i), vt[i].tx, vt[i].sl, vt[i].lp, vt[i].poke, vt[i].exp_rx);
        end

        // Reset during the 4th high phase aborts without a done pulse.
        clear_stats();
        loop = 1'b1;
        start = 1'b1; txdata = 8'hC7;
        tick();
        start = 1'b0;
        while (bits.size() < 4 && edge_n < 200) tick();
        check("abort reached 4th high", bits.size(), 4);
        tick();
        resetn = 1'b0;
        tick();
        check("abort cs", cs, 1'b1);
        check("abort sclk", sclk, 1'b0);
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort rxdata", rxdata, 8'h00);
        resetn = 1'b1;
        clear_stats();
        for (int i = 0; i < 20; i++) tick();
        check("abort no done", done_cnt, 0);
        xfer("post-abort", 8'h81, 8'h00, 1'b1, 0, 8'h81);

        // start held high: two frames separated by one idle cycle.
        clear_stats();
        loop = 1'b1;
        start = 1'b1; txdata = 8'h12;
        while (done_cnt == 0 && edge_n < 300) tick();
        txdata = 8'h34;
        tick();
        start = 1'b0;
        check("b2b second accepted", busy, 1'b1);
        while (done_cnt < 2 && edge_n < 600) tick();
        check("b2b done count", done_cnt, 2);
        check("b2b cs gap", cs_gap, 1);
        check("b2b mosi bits", pack_bits(), 16'h1234);
        check("b2b rx first", (rx_hist.size() > 0) ? rx_hist[0] : 8'hxx, 8'h12);
        check("b2b rx second", (rx_hist.size() > 1) ? rx_hist[1] : 8'hxx, 8'h34);
        check("b2b phase lengths", phase_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
